// File: rtl/side_ram_arbiter_if.sv
// rtl/side_ram_arbiter_if.sv - two-initiator side RAM bus (port A main CPU, port B sub CPU)
interface side_ram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              a_nCS;
  logic              a_nWE;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data_out;
  logic [DATA_W-1:0] a_data_in;
  logic              a_wait_n;
  logic              b_nCS;
  logic              b_nWE;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data_out;
  logic [DATA_W-1:0] b_data_in;
  logic              b_wait_n;

  // CPU side: drives strobes, address and write data
  modport master (
    output a_nCS, a_nWE, a_addr, a_data_out,
    input  a_data_in, a_wait_n,
    output b_nCS, b_nWE, b_addr, b_data_out,
    input  b_data_in, b_wait_n
  );

  // RAM side: returns read data and wait
  modport slave (
    input  a_nCS, a_nWE, a_addr, a_data_out,
    output a_data_in, a_wait_n,
    input  b_nCS, b_nWE, b_addr, b_data_out,
    output b_data_in, b_wait_n
  );
endinterface

// File: rtl/side_ram_arbiter.sv
// rtl/side_ram_arbiter.sv - round-robin arbiter in front of a shared single-port side RAM
module side_ram_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter     INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset_n,
  side_ram_arbiter_if.slave    bus,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC_A = 3'd1,
    S_ACC_B = 3'd2,
    S_RD_A  = 3'd3,
    S_RD_B  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_a_ncs_q;
  logic                r_b_ncs_q;
  logic                r_a_pend;
  logic                r_b_pend;
  logic                r_last_b;
  logic                r_a_we;
  logic                r_b_we;
  logic [ADDR_W-1:0]   r_a_addr;
  logic [ADDR_W-1:0]   r_b_addr;
  logic [DATA_W-1:0]   r_a_wdata;
  logic [DATA_W-1:0]   r_b_wdata;
  logic [DATA_W-1:0]   r_a_data_in;
  logic [DATA_W-1:0]   r_b_data_in;
  logic [DATA_W-1:0]   r_ram_rdata;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];

  logic                w_a_start;
  logic                w_b_start;
  logic                w_a_req;
  logic                w_b_req;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic                w_a_wait_n;
  logic                w_b_wait_n;

  // A start is a falling edge of nCS against the registered copy; the
  // registered copy resets high so a CPU already selecting at reset release
  // still starts exactly one access.
  assign w_a_start = !bus.a_nCS && r_a_ncs_q;
  assign w_b_start = !bus.b_nCS && r_b_ncs_q;
  // The start cycle already competes, so an idle RAM is granted immediately.
  assign w_a_req   = w_a_start || r_a_pend;
  assign w_b_req   = w_b_start || r_b_pend;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: on a tie the port not served last wins
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_a_req && w_b_req) w_next = r_last_b ? S_ACC_A : S_ACC_B;
        else if (w_a_req)       w_next = S_ACC_A;
        else if (w_b_req)       w_next = S_ACC_B;
      end
      S_ACC_A: w_next = r_a_we ? S_IDLE : S_RD_A;
      S_ACC_B: w_next = r_b_we ? S_IDLE : S_RD_B;
      S_RD_A:  w_next = S_IDLE;
      S_RD_B:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: grant, RAM drive, wait and busy decoded from state and pending
  always_comb begin
    w_grant_a   = (r_state == S_IDLE) && (w_next == S_ACC_A);
    w_grant_b   = (r_state == S_IDLE) && (w_next == S_ACC_B);
    w_ram_addr  = r_a_addr;
    w_ram_wdata = r_a_wdata;
    if (r_state == S_ACC_B) begin
      w_ram_addr  = r_b_addr;
      w_ram_wdata = r_b_wdata;
    end
    w_ram_we    = ((r_state == S_ACC_A) && r_a_we) || ((r_state == S_ACC_B) && r_b_we);
    w_a_wait_n  = !(w_a_start || r_a_pend || (r_state == S_ACC_A) || (r_state == S_RD_A));
    w_b_wait_n  = !(w_b_start || r_b_pend || (r_state == S_ACC_B) || (r_state == S_RD_B));
    busy        = (r_state != S_IDLE) || r_a_pend || r_b_pend;
  end

  assign bus.a_wait_n  = w_a_wait_n;
  assign bus.b_wait_n  = w_b_wait_n;
  assign bus.a_data_in = r_a_data_in;
  assign bus.b_data_in = r_b_data_in;

  // Per-port request tracking, request latches, round-robin memory and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_ncs_q   <= 1'b1;
      r_b_ncs_q   <= 1'b1;
      r_a_pend    <= 1'b0;
      r_b_pend    <= 1'b0;
      r_last_b    <= 1'b1;
      r_a_we      <= 1'b0;
      r_b_we      <= 1'b0;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_a_wdata   <= '0;
      r_b_wdata   <= '0;
      r_a_data_in <= '0;
      r_b_data_in <= '0;
    end else begin
      r_a_ncs_q <= bus.a_nCS;
      r_b_ncs_q <= bus.b_nCS;
      // Pending survives only while ungranted and still selected (nCS high aborts)
      r_a_pend  <= w_a_req && !w_grant_a && !bus.a_nCS;
      r_b_pend  <= w_b_req && !w_grant_b && !bus.b_nCS;
      if (w_a_start) begin
        r_a_addr  <= bus.a_addr;
        r_a_wdata <= bus.a_data_out;
        r_a_we    <= !bus.a_nWE;
      end
      if (w_b_start) begin
        r_b_addr  <= bus.b_addr;
        r_b_wdata <= bus.b_data_out;
        r_b_we    <= !bus.b_nWE;
      end
      if (r_state == S_ACC_A)      r_last_b <= 1'b0;
      else if (r_state == S_ACC_B) r_last_b <= 1'b1;
      if (r_state == S_RD_A) r_a_data_in <= r_ram_rdata;
      if (r_state == S_RD_B) r_b_data_in <= r_ram_rdata;
    end
  end

  // Single-port RAM, one-cycle read latency, contents not affected by reset
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
    r_ram_rdata <= r_mem[w_ram_addr];
  end

endmodule

// File: tb/tb_side_ram_arbiter.sv
// tb/tb_side_ram_arbiter.sv - scoreboard bench for side_ram_arbiter
module tb_side_ram_arbiter;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b1;
  logic prev_a   = 1'b1;
  logic prev_b   = 1'b1;
  exp_t qa[$];
  exp_t qb[$];

  side_ram_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  side_ram_arbiter #(.ADDR_W(13), .DATA_W(8), .INIT_FILE("")) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a rising wait_n marks a completed access; pop and compare
  task automatic complete(input bit p);
    exp_t e;
    if ((p ? qb.size() : qa.size()) == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_unexpected_completion: got completion at cycle %0d expected none", p ? "b" : "a", cyc);
    end else begin
      e = p ? qb.pop_front() : qa.pop_front();
      check(p ? "b_data_in" : "a_data_in", p ? bus.b_data_in : bus.a_data_in, e.d);
      check(p ? "b_done_cycle" : "a_done_cycle", cyc, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (!prev_a && bus.a_wait_n) complete(1'b0);
      if (!prev_b && bus.b_wait_n) complete(1'b1);
    end
    prev_a <= bus.a_wait_n;
    prev_b <= bus.b_wait_n;
  end

  // One CPU access: select, push expectation, hold until wait_n high, optionally keep nCS low
  task automatic access(input bit p, input bit we, input logic [12:0] addr, input logic [7:0] wd,
                        input logic [7:0] ed, input int lat, input int hold);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    if (!p) begin
      bus.a_nCS = 1'b0; bus.a_nWE = !we; bus.a_addr = addr; bus.a_data_out = wd;
    end else begin
      bus.b_nCS = 1'b0; bus.b_nWE = !we; bus.b_addr = addr; bus.b_data_out = wd;
    end
    e.d = ed;
    e.c = cyc + lat;
    if (!p) qa.push_back(e);
    else    qb.push_back(e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((p ? bus.b_wait_n : bus.a_wait_n) == 1'b0) && (k < 30));
    check(p ? "b_wait_timeout" : "a_wait_timeout", p ? bus.b_wait_n : bus.a_wait_n, 1);
    if (hold > 0) begin
      check("busy_at_done", busy, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("busy_while_held", busy, 0);
      end
    end
    @(posedge clk); #1;
    if (!p) begin bus.a_nCS = 1'b1; bus.a_nWE = 1'b1; end
    else    begin bus.b_nCS = 1'b1; bus.b_nWE = 1'b1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected end before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a_nCS = 1'b1; bus.a_nWE = 1'b1; bus.a_addr = '0; bus.a_data_out = '0;
    bus.b_nCS = 1'b1; bus.b_nWE = 1'b1; bus.b_addr = '0; bus.b_data_out = '0;

    // Reset state
    @(negedge clk);
    check("rst_a_wait_n", bus.a_wait_n, 1);
    check("rst_b_wait_n", bus.b_wait_n, 1);
    check("rst_busy", busy, 0);
    check("rst_a_data_in", bus.a_data_in, 0);
    check("rst_b_data_in", bus.b_data_in, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Uncontended write then read on A
    access(0, 1, 13'h0010, 8'h5A, 8'h00, 2, 0);
    access(0, 0, 13'h0010, 8'h00, 8'h5A, 3, 0);
    // Preload for the tie test; B write leaves last grant on B
    access(0, 1, 13'h0000, 8'h11, 8'h5A, 2, 0);
    access(1, 1, 13'h1FFF, 8'h22, 8'h00, 2, 0);

    // Simultaneous reads: A wins, B waits 3 extra
    fork
      access(0, 0, 13'h0000, 8'h00, 8'h11, 3, 0);
      access(1, 0, 13'h1FFF, 8'h00, 8'h22, 6, 0);
    join
    // Tie again after B was last: A first
    fork
      access(0, 0, 13'h0010, 8'h00, 8'h5A, 3, 0);
      access(1, 0, 13'h0000, 8'h00, 8'h11, 6, 0);
    join
    // Lone A access moves last grant to A
    access(0, 1, 13'h0020, 8'h77, 8'h5A, 2, 0);
    // Tie: B first now
    fork
      access(0, 0, 13'h0020, 8'h00, 8'h77, 6, 0);
      access(1, 0, 13'h0010, 8'h00, 8'h5A, 3, 0);
    join
    // Write tie, A served last before: B first, A waits 2 extra
    fork
      access(0, 1, 13'h0030, 8'h33, 8'h77, 4, 0);
      access(1, 1, 13'h0031, 8'h44, 8'h5A, 2, 0);
    join
    // Read tie, A served last: B first
    fork
      access(0, 0, 13'h0031, 8'h00, 8'h44, 6, 0);
      access(1, 0, 13'h0030, 8'h00, 8'h33, 3, 0);
    join

    // A writes, B reads same address one cycle later
    fork
      access(0, 1, 13'h0123, 8'hC3, 8'h44, 2, 0);
      begin
        @(posedge clk);
        access(1, 0, 13'h0123, 8'h00, 8'hC3, 4, 0);
      end
    join

    // B keeps nCS low 10 clk after one read: single access only
    access(1, 0, 13'h0010, 8'h00, 8'h5A, 3, 10);

    // Reset while A reads and B is pending
    @(posedge clk); #1;
    mon_en = 1'b0;
    bus.a_nCS = 1'b0; bus.a_nWE = 1'b1; bus.a_addr = 13'h0010;
    @(posedge clk); #1;
    bus.b_nCS = 1'b0; bus.b_nWE = 1'b1; bus.b_addr = 13'h0020;
    @(negedge clk);
    check("pre_rst_a_wait_n", bus.a_wait_n, 0);
    check("pre_rst_b_wait_n", bus.b_wait_n, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.a_nCS = 1'b1; bus.b_nCS = 1'b1;
    #1;
    check("mid_rst_a_wait_n", bus.a_wait_n, 1);
    check("mid_rst_b_wait_n", bus.b_wait_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_a_data_in", bus.a_data_in, 0);
    check("mid_rst_b_data_in", bus.b_data_in, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    access(0, 0, 13'h0010, 8'h00, 8'h5A, 3, 0);

    repeat (3) @(posedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
